// File: rtl/exc_sequencer_pkg.sv
// exc_sequencer_pkg: ExcCode constants, handler address and sequencer state encodings.
package exc_sequencer_pkg;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTER = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  typedef enum logic [1:0] {ACT_NONE, ACT_EXC, ACT_ERET} act_t;
endpackage

// File: rtl/exc_sequencer_prio.sv
// exc_prio_enc: picks interrupt > exception > ERET and forms the Cause code and EPC value.
module exc_prio_enc
  import exc_sequencer_pkg::*;
(
  input  logic        i_int_pend,
  input  logic        i_exl,
  input  logic        i_eret,
  input  logic        i_bd,
  input  logic [4:0]  i_exc_code,
  input  logic [31:0] i_pc,
  output act_t        o_act,
  output logic [4:0]  o_code,
  output logic [31:0] o_epc
);
  logic w_exc;
  logic w_eret;
  // EXL masks entry; ERET is only meaningful while EXL is set and nothing else is pending
  always_comb begin
    w_exc  = !i_exl && (i_int_pend || i_exc_code != EXC_INT);
    w_eret = i_exl && i_eret && !i_int_pend && i_exc_code == EXC_INT;
    o_act  = w_exc ? ACT_EXC : w_eret ? ACT_ERET : ACT_NONE;
    o_code = i_int_pend ? EXC_INT : i_exc_code;
    o_epc  = {i_pc[31:2], 2'b00} - (i_bd ? 32'd4 : 32'd0);
  end
endmodule

// File: rtl/exc_sequencer.sv
// exc_sequencer: M-stage exception/interrupt entry and ERET sequencer driving CP0 strobes,
// pipeline flush and fetch redirect, with a drain window blocking re-entry.
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC   = HANDLER_PC_DEF,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_m,
  input  logic        hold_m,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic        int_pend,
  input  logic        cp0_exl,
  input  logic [31:0] cp0_epc,
  output logic        cp0_exc_we,
  output logic [4:0]  cp0_exccode,
  output logic [31:0] cp0_pc,
  output logic        cp0_bd,
  output logic        cp0_exl_clr,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);
  localparam logic [7:0] CNT_LOAD = 8'(DRAIN_CYCLES - 1);
  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_exc_we;
  logic        r_exl_clr;
  logic        r_flush;
  logic [4:0]  r_exccode;
  logic [31:0] r_pc;
  logic        r_bd;
  logic [31:0] r_redirect_pc;
  act_t        w_act;
  logic [4:0]  w_code;
  logic [31:0] w_epc;
  logic        w_go;
  logic        w_exc;
  exc_prio_enc u_enc (
    .i_int_pend (int_pend),
    .i_exl      (cp0_exl),
    .i_eret     (eret_m),
    .i_bd       (bd_m),
    .i_exc_code (exc_code_m),
    .i_pc       (pc_m),
    .o_act      (w_act),
    .o_code     (w_code),
    .o_epc      (w_epc)
  );
  always_comb begin
    w_go  = r_state == ST_IDLE && valid_m && !hold_m && w_act != ACT_NONE;
    w_exc = w_go && w_act == ACT_EXC;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_exc_we      <= 1'b0;
      r_exl_clr     <= 1'b0;
      r_flush       <= 1'b0;
      r_exccode     <= '0;
      r_pc          <= '0;
      r_bd          <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_exc_we  <= w_exc;
      r_exl_clr <= w_go && w_act == ACT_ERET;
      r_flush   <= w_go;
      if (w_exc) begin
        r_exccode <= w_code;
        r_pc      <= w_epc;
        r_bd      <= bd_m;
      end
      if (w_go) r_redirect_pc <= w_exc ? HANDLER_PC : cp0_epc;
      r_state <= w_go ? ST_ENTER :
                 r_state == ST_ENTER ? ST_DRAIN :
                 (r_state == ST_DRAIN && r_cnt == 8'd0) ? ST_IDLE : r_state;
      r_cnt   <= r_state == ST_ENTER ? CNT_LOAD :
                 (r_state == ST_DRAIN && r_cnt != 8'd0) ? r_cnt - 8'd1 : r_cnt;
    end
  end
  assign cp0_exc_we  = r_exc_we;
  assign cp0_exl_clr = r_exl_clr;
  assign flush       = r_flush;
  assign redirect    = r_flush;
  assign cp0_exccode = r_exccode;
  assign cp0_pc      = r_pc;
  assign cp0_bd      = r_bd;
  assign redirect_pc = r_redirect_pc;
  assign busy        = r_state != ST_IDLE;
endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: directed plus random stimulus; expected entries/ERETs queued by a
// behavioural model and checked by an independent monitor.
module tb_exc_sequencer;
  localparam logic [31:0] HPC = 32'h0000_4180;
  localparam int DR = 3;
  typedef struct {
    int          cyc;
    bit          exc;
    bit          eret;
    logic [4:0]  code;
    logic [31:0] pc;
    bit          bd;
    logic [31:0] rpc;
  } exp_t;
  logic clk = 0, reset_n = 0, valid_m = 0, hold_m = 0, bd_m = 0, eret_m = 0;
  logic int_pend = 0, cp0_exl = 0;
  logic [31:0] pc_m = 0, cp0_epc = 0;
  logic [4:0] exc_code_m = 0;
  logic cp0_exc_we, cp0_bd, cp0_exl_clr, flush, redirect, busy;
  logic [4:0] cp0_exccode;
  logic [31:0] cp0_pc, redirect_pc;
  int ecount = 0;
  int busy_until = -10;
  int total = 0, bad = 0;
  exp_t q[$];
  exc_sequencer #(.HANDLER_PC(HPC), .DRAIN_CYCLES(DR)) dut (
    .clk(clk), .reset_n(reset_n), .valid_m(valid_m), .hold_m(hold_m), .pc_m(pc_m),
    .bd_m(bd_m), .exc_code_m(exc_code_m), .eret_m(eret_m), .int_pend(int_pend),
    .cp0_exl(cp0_exl), .cp0_epc(cp0_epc), .cp0_exc_we(cp0_exc_we), .cp0_exccode(cp0_exccode),
    .cp0_pc(cp0_pc), .cp0_bd(cp0_bd), .cp0_exl_clr(cp0_exl_clr), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h (edge %0d)", n, a, e, ecount);
    end
  endtask
  // model: an action at edge e blocks new actions until edge e+DR+2; reset clears everything
  task automatic drv(bit rn, bit v, bit h, bit bd, bit er, bit ip, bit exl,
                     logic [4:0] code, logic [31:0] pc, logic [31:0] epc);
    int e;
    exp_t x;
    @(negedge clk);
    reset_n = rn; valid_m = v; hold_m = h; bd_m = bd; eret_m = er; int_pend = ip;
    cp0_exl = exl; exc_code_m = code; pc_m = pc; cp0_epc = epc;
    e = ecount + 1;
    x = '{cyc: e, exc: 0, eret: 0, code: 0, pc: 0, bd: 0, rpc: 0};
    if (!rn) begin
      busy_until = -10;
    end else if (v && !h && e >= busy_until + 2) begin
      if (!exl && (ip || code != 0)) begin
        x.exc = 1; x.code = ip ? 5'd0 : code; x.bd = bd; x.rpc = HPC;
        x.pc = {pc[31:2], 2'b00} - (bd ? 32'd4 : 32'd0);
      end else if (exl && er && !ip && code == 0) begin
        x.eret = 1; x.rpc = epc;
      end
      if (x.exc || x.eret) begin
        q.push_back(x);
        busy_until = e + DR;
      end
    end
  endtask
  task automatic idle();
    drv(1, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
  endtask
  always @(posedge clk) begin
    exp_t x;
    #2;
    chk("busy", 32'(busy), 32'(ecount <= busy_until));
    if (cp0_exc_we || cp0_exl_clr || flush || redirect) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe: got we=%b clr=%b flush=%b redir=%b want none (edge %0d)",
                 cp0_exc_we, cp0_exl_clr, flush, redirect, ecount);
      end else begin
        x = q.pop_front();
        chk("when", ecount, x.cyc);
        chk("exc_we", 32'(cp0_exc_we), 32'(x.exc));
        chk("exl_clr", 32'(cp0_exl_clr), 32'(x.eret));
        chk("flush_redir", {30'd0, flush, redirect}, 32'd3);
        chk("redirect_pc", redirect_pc, x.rpc);
        if (x.exc) begin
          chk("exccode", 32'(cp0_exccode), 32'(x.code));
          chk("cp0_pc", cp0_pc, x.pc);
          chk("cp0_bd", 32'(cp0_bd), 32'(x.bd));
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= ecount) begin
      x = q.pop_front();
      total++; bad++;
      $display("FAIL missing_strobe: got none want action due edge %0d (edge %0d)", x.cyc, ecount);
    end
  end
  initial begin
    logic [4:0] codes [5] = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
    repeat (3) drv(0, 1, 0, 0, 0, 1, 0, 5'd12, 32'h100, 32'd0);
    chk("rst_vals", {cp0_exccode, cp0_bd}, 32'd0);
    chk("rst_pc", cp0_pc, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    idle();
    drv(1, 1, 0, 0, 0, 0, 0, 5'd12, 32'h3010, 32'd0);
    repeat (6) idle();
    drv(1, 1, 0, 1, 0, 1, 0, 5'd4, 32'h3024, 32'd0);
    repeat (6) idle();
    repeat (3) drv(1, 0, 0, 0, 0, 1, 0, 5'd0, 32'h3100, 32'd0);
    drv(1, 1, 0, 0, 0, 1, 0, 5'd0, 32'h3100, 32'd0);
    repeat (6) idle();
    drv(1, 1, 0, 0, 1, 0, 1, 5'd0, 32'h3050, 32'h3020);
    repeat (3) drv(1, 1, 0, 0, 0, 1, 0, 5'd0, 32'h3060, 32'd0);
    repeat (4) idle();
    repeat (2) drv(1, 1, 1, 0, 0, 0, 0, 5'd10, 32'h3070, 32'd0);
    drv(1, 1, 0, 0, 0, 0, 0, 5'd10, 32'h3070, 32'd0);
    repeat (6) idle();
    drv(1, 1, 0, 1, 0, 0, 0, 5'd12, 32'h0, 32'd0);
    repeat (6) idle();
    drv(1, 1, 0, 0, 1, 0, 0, 5'd0, 32'h3080, 32'h3000);
    drv(1, 1, 0, 0, 1, 0, 1, 5'd5, 32'h3084, 32'h3000);
    repeat (5) idle();
    drv(1, 1, 0, 0, 0, 0, 0, 5'd12, 32'h3090, 32'd0);
    repeat (2) idle();
    drv(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
    drv(1, 1, 0, 0, 0, 0, 0, 5'd5, 32'h30A3, 32'd0);
    repeat (6) idle();
    repeat (3000) drv($urandom_range(0, 40) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 2) == 0, codes[$urandom_range(0, 4)],
                      $urandom(), $urandom());
    repeat (8) idle();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
